// File: rtl/panda_pkg.sv
// Shared types and constants for the panda core's instruction memory and IF stage.
// The NOP encoding is reused by the IF flush path.
package panda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } imem_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage : panda_pkg

// File: rtl/panda_imem_if.sv
// Byte-stream image-load channel into the instruction memory.
// The host drives the master side; panda_imem consumes the slave side.
interface panda_imem_if;

  logic       load_start;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_byte;
  logic       load_last;

  modport master (
    output load_start,
    output load_valid,
    output load_byte,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_start,
    input  load_valid,
    input  load_byte,
    input  load_last,
    output load_ready
  );

endinterface : panda_imem_if

// File: rtl/panda_imem_loader.sv
// Image loader: assembles little-endian bytes into words and emits one word write per
// completed (or final partial) word, with overflow detection against Depth.
module panda_imem_loader
  import panda_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  panda_imem_if.slave       load_if,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              we_o,
  output logic [AW-1:0]     waddr_o,
  output logic [31:0]       wdata_o
);

  imem_state_e state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;     // one extra bit so ptr can reach Depth
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        err_q, err_d;

  logic        accept;
  logic        full;
  logic [31:0] word_merged;

  assign full        = (ptr_q == (AW + 1)'(Depth));
  assign word_merged = asm_q | ({24'h0, load_if.load_byte} << {cnt_q, 3'b000});

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    cnt_d              = cnt_q;
    asm_d              = asm_q;
    err_d              = err_q;
    we_o               = 1'b0;
    waddr_o            = ptr_q[AW-1:0];
    wdata_o            = word_merged;
    load_if.load_ready = 1'b0;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    accept             = 1'b0;

    unique case (state_q)
      IDLE, ERR: begin
        if (load_if.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        load_if.load_ready = 1'b1;
        busy_o             = 1'b1;
        accept             = load_if.load_valid;
        if (accept) begin
          if (full) begin
            // Image larger than the array: drop the byte and flag it.
            state_d = ERR;
            err_d   = 1'b1;
          end else if (cnt_q == 2'(BYTES_PER_WORD - 1) || load_if.load_last) begin
            we_o  = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = '0;
            asm_d = '0;
            if (load_if.load_last) begin
              state_d = DONE;
            end
          end else begin
            asm_d = word_merged;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign err_o = err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
    end
  end

endmodule : panda_imem_loader

// File: rtl/panda_imem.sv
// Instruction memory: combinational fetch port plus a byte-stream image loader.
// Fetches return NOP while a load is in progress or when the address is out of range.
module panda_imem
  import panda_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  panda_imem_if.slave load_if,
  output logic        busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  logic [31:0]   mem [Depth];
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  panda_imem_loader #(.Depth(Depth)) u_loader (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_if (load_if),
    .busy_o  (busy_o),
    .done_o  (load_done_o),
    .err_o   (load_err_o),
    .we_o    (we),
    .waddr_o (waddr),
    .wdata_o (wdata)
  );

  // NOTE: the array has no reset; it keeps its image across rst_i and maps
  // onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  logic [AW-1:0] rd_idx;
  logic          rd_oob;
  logic          unused_byte_offset;

  assign rd_idx             = instr_addr_i[AW+1:2];
  assign rd_oob             = |instr_addr_i[31:AW+2];
  assign unused_byte_offset = ^instr_addr_i[1:0];

  // Same-cycle write to the read word returns the old contents: write lands at the edge.
  always_comb begin
    instr_rdata_o = mem[rd_idx];
    if (rd_oob || busy_o) begin
      instr_rdata_o = NOP_INSTR;
    end
  end

endmodule : panda_imem

// File: tb/tb_panda_imem.sv
// Directed bench for panda_imem: a Depth=1024 instance for load/read cases and a
// Depth=4 instance for the overflow path.
module tb_panda_imem;

  logic        clk;
  logic        rst;
  logic [31:0] addr_big, addr_small;
  logic [31:0] rdata_big, rdata_small;
  logic        busy_big, done_big, err_big;
  logic        busy_small, done_small, err_small;

  logic        tgt;   // 0 drives the Depth=1024 instance, 1 the Depth=4 instance
  logic        start, valid, last;
  logic [7:0]  bval;
  logic        rdy;

  int tests  = 0;
  int fails  = 0;
  int done_cnt = 0;

  panda_imem_if if_big ();
  panda_imem_if if_small ();

  assign if_big.load_start   = start & ~tgt;
  assign if_big.load_valid   = valid & ~tgt;
  assign if_big.load_byte    = bval;
  assign if_big.load_last    = last;
  assign if_small.load_start = start & tgt;
  assign if_small.load_valid = valid & tgt;
  assign if_small.load_byte  = bval;
  assign if_small.load_last  = last;
  assign rdy = tgt ? if_small.load_ready : if_big.load_ready;

  panda_imem #(.Depth(1024)) u_big (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_addr_i (addr_big),
    .instr_rdata_o(rdata_big),
    .load_if      (if_big.slave),
    .busy_o       (busy_big),
    .load_done_o  (done_big),
    .load_err_o   (err_big)
  );

  panda_imem #(.Depth(4)) u_small (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_addr_i (addr_small),
    .instr_rdata_o(rdata_small),
    .load_if      (if_small.slave),
    .busy_o       (busy_small),
    .load_done_o  (done_small),
    .load_err_o   (err_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_big) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
    int n;
    repeat (gap) tick();
    valid = 1'b1;
    bval  = b;
    last  = l;
    n = 0;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    if (!rdy) check("ready_timeout", {31'b0, rdy}, 32'h1);
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic rd_big(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_big = a;
    #1;
    check(tag, rdata_big, exp);
  endtask

  task automatic rd_small(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_small = a;
    #1;
    check(tag, rdata_small, exp);
  endtask

  logic [7:0] img8  [8]  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] img5  [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] img12 [12] = '{8'hef, 8'hbe, 8'had, 8'hde, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'h0d, 8'hf0, 8'hfe, 8'hca};

  initial begin
    rst = 1'b1; tgt = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0; bval = 8'h00;
    addr_big = 32'h0; addr_small = 32'h0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",  {31'b0, busy_big},           32'h0);
    check("rst_ready", {31'b0, if_big.load_ready},  32'h0);
    check("rst_done",  {31'b0, done_big},           32'h0);
    check("rst_err",   {31'b0, err_big},            32'h0);
    check("rst_err4",  {31'b0, err_small},          32'h0);

    // Two-word image with last on byte 8
    pulse_start();
    check("load_busy",  {31'b0, busy_big},          32'h1);
    check("load_ready", {31'b0, if_big.load_ready}, 32'h1);
    rd_big("busy_nop", 32'h0, 32'h0000_0013);
    for (int i = 0; i < 8; i++) send_byte(img8[i], i == 7, 0);
    check("done_pulse", {31'b0, done_big}, 32'h1);
    check("done_busy",  {31'b0, busy_big}, 32'h1);
    tick();
    check("done_gone",  {31'b0, done_big}, 32'h0);
    check("idle_busy",  {31'b0, busy_big}, 32'h0);
    check("done_count", done_cnt,          32'd1);
    rd_big("w0_nop",     32'h0000_0000, 32'h0000_0013);
    rd_big("w1_addi",    32'h0000_0004, 32'h0010_0093);
    rd_big("addr7_w1",   32'h0000_0007, 32'h0010_0093);
    rd_big("oob_1000",   32'h0000_1000, 32'h0000_0013);
    rd_big("oob_msb",    32'h8000_0004, 32'h0000_0013);

    // Five-byte image; start mid-load and in DONE must be ignored
    pulse_start();
    send_byte(img5[0], 1'b0, 0);
    send_byte(img5[1], 1'b0, 0);
    pulse_start();
    for (int i = 2; i < 5; i++) send_byte(img5[i], i == 4, 0);
    check("b5_busy_hold", {31'b0, busy_big}, 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b5_busy_fall", {31'b0, busy_big}, 32'h0);
    rd_big("b5_w0", 32'h0, 32'h4433_2211);
    rd_big("b5_w1", 32'h4, 32'h0000_0055);

    // Reset after two bytes of the second word
    pulse_start();
    send_byte(8'ha1, 1'b0, 0);
    send_byte(8'ha2, 1'b0, 0);
    send_byte(8'ha3, 1'b0, 0);
    send_byte(8'ha4, 1'b0, 0);
    send_byte(8'hb1, 1'b0, 0);
    send_byte(8'hb2, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy",  {31'b0, busy_big},          32'h0);
    check("rstmid_ready", {31'b0, if_big.load_ready}, 32'h0);
    rd_big("rstmid_w0", 32'h0, 32'ha4a3_a2a1);
    rd_big("rstmid_w1", 32'h4, 32'h0000_0055);

    // Image with random valid gaps matches the byte stream
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(img12[i], i == 11, int'($urandom_range(0, 3)));
    tick();
    rd_big("gap_w0", 32'h0, 32'hdead_beef);
    rd_big("gap_w1", 32'h4, 32'h1234_5678);
    rd_big("gap_w2", 32'h8, 32'hcafe_f00d);

    // Overflow on the Depth=4 instance
    tgt = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0, 0);
    check("ovf_pre_err",  {31'b0, err_small},  32'h0);
    check("ovf_pre_busy", {31'b0, busy_small}, 32'h1);
    send_byte(8'hee, 1'b0, 0);
    check("ovf_err",   {31'b0, err_small},          32'h1);
    check("ovf_busy",  {31'b0, busy_small},         32'h0);
    check("ovf_ready", {31'b0, if_small.load_ready}, 32'h0);
    repeat (3) tick();
    check("ovf_sticky", {31'b0, err_small}, 32'h1);
    rd_small("ovf_w0",  32'h0,  32'h0403_0201);
    rd_small("ovf_w1",  32'h4,  32'h0807_0605);
    rd_small("ovf_w2",  32'h8,  32'h0c0b_0a09);
    rd_small("ovf_w3",  32'hc,  32'h100f_0e0d);
    rd_small("ovf_oob", 32'h10, 32'h0000_0013);
    pulse_start();
    check("restart_err",  {31'b0, err_small},  32'h0);
    check("restart_busy", {31'b0, busy_small}, 32'h1);
    send_byte(8'h77, 1'b1, 0);
    check("restart_done", {31'b0, done_small}, 32'h1);
    tick();
    rd_small("restart_w0", 32'h0, 32'h0000_0077);
    rd_small("restart_w1", 32'h4, 32'h0807_0605);
    rd_big("big_intact", 32'h4, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_panda_imem
